// File: rtl/jk_updown_counter.sv
// rtl/jk_updown_counter.sv - mod-N up/down counter producing JK excitation for an external flip-flop bank
//
// Purpose:
//   Holds the reference count, updated on the falling edge of clk. It presents
//   the J/K inputs that move an external bank of falling-edge JK flip-flops
//   from q to the value this register takes on the same edge, so that bank
//   tracks q exactly. It also provides terminal-count and wrap indications for
//   cascading stages.
//
// Ports:
//   clk      in   clock; all state changes on the falling edge
//   clr      in   synchronous active-high clear (highest priority)
//   en       in   count enable
//   up       in   direction, 1 = increment, 0 = decrement
//   load     in   synchronous parallel load (beats en)
//   load_val in   WIDTH   value to load; clamped to MODULUS-1
//   q        out  WIDTH   registered count
//   qb       out  WIDTH   bitwise complement of q
//   j_out    out  WIDTH   J excitation for the pending transition
//   k_out    out  WIDTH   K excitation for the pending transition
//   tc       out  terminal count in the current direction, independent of en
//   wrap     out  one-cycle registered pulse after a wrap-around
module jk_updown_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             tc,
  output logic             wrap
);

  // MODULUS-1 always fits in WIDTH bits because MODULUS <= 2^WIDTH. The load
  // comparison uses one extra bit so that MODULUS == 2^WIDTH does not
  // overflow to zero.
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_zero;

  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

  // This next-state value drives both the register and the excitation. The
  // external bank therefore always lands on the same value as q_q.
  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        q_d = load_val;
      end else begin
        q_d = MAX_VAL;
      end
    end else if (en) begin
      if (up) begin
        if (at_max) begin
          q_d    = '0;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          q_d    = MAX_VAL;
          wrap_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  always_ff @(negedge clk) begin
    if (clr) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  // Bits that keep their value get J=K=0, so don't-care cases resolve to 0
  // and J and K are never asserted together.
  assign j_out = ~q_q & q_d;
  assign k_out = q_q & ~q_d;

  assign tc   = (up & at_max) | (~up & at_zero);
  assign q    = q_q;
  assign qb   = ~q_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_updown_counter.sv
// tb/tb_jk_updown_counter.sv - self-checking bench for jk_updown_counter
module tb_jk_updown_counter;

  logic       clk = 1'b0;
  logic       clr, en, up, load;
  logic [3:0] load_val;

  logic [3:0] q_a, qb_a, j_a, k_a;
  logic       tc_a, wrap_a;
  logic [3:0] q_b, qb_b, j_b, k_b;
  logic       tc_b, wrap_b;

  int n_tests = 0;
  int n_fail  = 0;

  int         ma, mb, nq, nqb;
  logic       w, wb;
  logic [3:0] exp_j, exp_k, shadow;

  always #5 clk = ~clk;

  jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut_a (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_a), .qb(qb_a), .j_out(j_a), .k_out(k_a), .tc(tc_a), .wrap(wrap_a)
  );

  jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut_b (
    .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .load_val(load_val),
    .q(q_b), .qb(qb_b), .j_out(j_b), .k_out(k_b), .tc(tc_b), .wrap(wrap_b)
  );

  // Stand-in for the external JK flip-flop bank wired to dut_a's excitation.
  always @(negedge clk) shadow = (j_a & ~shadow) | (~k_a & shadow);

  // Reference counter over integers with modular arithmetic.
  task automatic model_step(input int m, input int q, input logic c, input logic l,
                            input logic [3:0] lv, input logic e, input logic u,
                            output int nxt, output logic wr);
    wr  = 1'b0;
    nxt = q;
    if (c) nxt = 0;
    else if (l) nxt = (int'(lv) < m) ? int'(lv) : m - 1;
    else if (e) begin
      if (u) begin nxt = (q + 1) % m;     wr = (q == m - 1); end
      else   begin nxt = (q + m - 1) % m; wr = (q == 0);     end
    end
  endtask

  task automatic apply(input logic c, input logic l, input logic [3:0] lv,
                       input logic e, input logic u);
    clr = c; load = l; load_val = lv; en = e; up = u;
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 0, 1);
    tick();
    n_tests++; if (q_a !== 4'd0) begin n_fail++; $display("FAIL reset_q: got %0d expected 0", q_a); end
    n_tests++; if (qb_a !== 4'b1111) begin n_fail++; $display("FAIL reset_qb: got %b expected 1111", qb_a); end
    n_tests++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL reset_wrap: got %b expected 0", wrap_a); end
    apply(0, 1, 4'd7, 0, 1);
    tick();
    n_tests++; if (q_a !== 4'd7) begin n_fail++; $display("FAIL reset_pre7: got %0d expected 7", q_a); end
    apply(1, 0, 0, 1, 1);
    n_tests++; if (j_a !== 4'b0000) begin n_fail++; $display("FAIL reset_j: got %b expected 0000", j_a); end
    n_tests++; if (k_a !== 4'b0111) begin n_fail++; $display("FAIL reset_k: got %b expected 0111", k_a); end
    tick();
    tick();
    n_tests++; if (q_a !== 4'd0) begin n_fail++; $display("FAIL reset_q2: got %0d expected 0", q_a); end
    n_tests++; if (qb_a !== 4'b1111) begin n_fail++; $display("FAIL reset_qb2: got %b expected 1111", qb_a); end
    n_tests++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL reset_wrap2: got %b expected 0", wrap_a); end
    ma = 0;
  endtask

  task automatic test_up_count();
    apply(0, 0, 0, 1, 1);
    for (int i = 0; i < 12; i++) begin
      model_step(10, ma, 0, 0, 0, 1, 1, nq, w);
      exp_j = ~4'(ma) & 4'(nq);
      exp_k = 4'(ma) & ~4'(nq);
      n_tests++; if (tc_a !== (ma == 9)) begin n_fail++; $display("FAIL up_tc: q=%0d got %b expected %b", ma, tc_a, ma == 9); end
      n_tests++; if (j_a !== exp_j || k_a !== exp_k) begin n_fail++; $display("FAIL up_jk: q=%0d got j=%b k=%b expected j=%b k=%b", ma, j_a, k_a, exp_j, exp_k); end
      if (ma == 9) begin
        n_tests++; if (j_a !== 4'b0000 || k_a !== 4'b1001) begin n_fail++; $display("FAIL up_jk_at9: got j=%b k=%b expected j=0000 k=1001", j_a, k_a); end
      end
      tick();
      ma = nq;
      n_tests++; if (q_a !== 4'((i + 1) % 10)) begin n_fail++; $display("FAIL up_q: step %0d got %0d expected %0d", i, q_a, (i + 1) % 10); end
      n_tests++; if (wrap_a !== w) begin n_fail++; $display("FAIL up_wrap: step %0d got %b expected %b", i, wrap_a, w); end
    end
  endtask

  task automatic test_down_count();
    apply(0, 1, 4'd1, 0, 0);
    tick();
    ma = 1;
    apply(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      model_step(10, ma, 0, 0, 0, 1, 0, nq, w);
      exp_j = ~4'(ma) & 4'(nq);
      exp_k = 4'(ma) & ~4'(nq);
      n_tests++; if (tc_a !== (ma == 0)) begin n_fail++; $display("FAIL down_tc: q=%0d got %b expected %b", ma, tc_a, ma == 0); end
      n_tests++; if (j_a !== exp_j || k_a !== exp_k) begin n_fail++; $display("FAIL down_jk: q=%0d got j=%b k=%b expected j=%b k=%b", ma, j_a, k_a, exp_j, exp_k); end
      if (ma == 0) begin
        n_tests++; if (j_a !== 4'b1001 || k_a !== 4'b0000) begin n_fail++; $display("FAIL down_jk_at0: got j=%b k=%b expected j=1001 k=0000", j_a, k_a); end
      end
      tick();
      ma = nq;
      n_tests++; if (q_a !== 4'(nq)) begin n_fail++; $display("FAIL down_q: step %0d got %0d expected %0d", i, q_a, nq); end
      n_tests++; if (wrap_a !== w) begin n_fail++; $display("FAIL down_wrap: step %0d got %b expected %b", i, wrap_a, w); end
    end
  endtask

  task automatic test_load();
    logic [3:0] vals [4];
    logic       clrs [4];
    logic       ens  [4];
    int         exps [4];
    vals = '{4'd5, 4'd14, 4'd3, 4'd8};
    clrs = '{1'b0, 1'b0, 1'b0, 1'b1};
    ens  = '{1'b0, 1'b0, 1'b1, 1'b1};
    exps = '{5, 9, 3, 0};
    for (int i = 0; i < 4; i++) begin
      apply(clrs[i], 1, vals[i], ens[i], 1);
      tick();
      ma = exps[i];
      n_tests++; if (q_a !== 4'(exps[i])) begin n_fail++; $display("FAIL load_q: case %0d got %0d expected %0d", i, q_a, exps[i]); end
      n_tests++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL load_wrap: case %0d got %b expected 0", i, wrap_a); end
    end
  endtask

  task automatic test_hold();
    apply(0, 1, 4'd6, 0, 1);
    tick();
    ma = 6;
    apply(0, 0, 4'd2, 0, 1);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (j_a !== 4'b0000 || k_a !== 4'b0000) begin n_fail++; $display("FAIL hold_jk: got j=%b k=%b expected 0000/0000", j_a, k_a); end
      tick();
      n_tests++; if (q_a !== 4'd6) begin n_fail++; $display("FAIL hold_q: got %0d expected 6", q_a); end
      n_tests++; if (wrap_a !== 1'b0) begin n_fail++; $display("FAIL hold_wrap: got %b expected 0", wrap_a); end
    end
  endtask

  task automatic test_random_shadow();
    logic       r_e, r_u, r_l;
    logic [3:0] r_v;
    apply(1, 0, 0, 0, 1);
    tick();
    ma = 0;
    shadow = 4'd0;
    for (int i = 0; i < 200; i++) begin
      r_e = 1'($urandom_range(0, 3) != 0);
      r_u = 1'($urandom_range(0, 1));
      r_l = 1'($urandom_range(0, 9) == 0);
      r_v = 4'($urandom_range(0, 15));
      apply(0, r_l, r_v, r_e, r_u);
      n_tests++; if (tc_a !== ((r_u && ma == 9) || (!r_u && ma == 0))) begin n_fail++; $display("FAIL rand_tc: step %0d q=%0d up=%b got %b", i, ma, r_u, tc_a); end
      model_step(10, ma, 0, r_l, r_v, r_e, r_u, nq, w);
      tick();
      ma = nq;
      n_tests++; if (q_a !== 4'(nq)) begin n_fail++; $display("FAIL rand_q: step %0d got %0d expected %0d", i, q_a, nq); end
      n_tests++; if (shadow !== 4'(nq)) begin n_fail++; $display("FAIL rand_shadow: step %0d got %0d expected %0d", i, shadow, nq); end
      n_tests++; if (wrap_a !== w) begin n_fail++; $display("FAIL rand_wrap: step %0d got %b expected %b", i, wrap_a, w); end
      n_tests++; if (qb_a !== ~4'(nq)) begin n_fail++; $display("FAIL rand_qb: step %0d got %b expected %b", i, qb_a, ~4'(nq)); end
    end
  endtask

  task automatic test_mod16();
    apply(0, 1, 4'd15, 0, 1);
    tick();
    mb = 15;
    n_tests++; if (q_b !== 4'd15) begin n_fail++; $display("FAIL m16_load: got %0d expected 15", q_b); end
    n_tests++; if (tc_b !== 1'b1) begin n_fail++; $display("FAIL m16_tc15: got %b expected 1", tc_b); end
    apply(0, 0, 0, 1, 1);
    model_step(16, mb, 0, 0, 0, 1, 1, nqb, wb);
    tick();
    mb = nqb;
    n_tests++; if (q_b !== 4'(nqb)) begin n_fail++; $display("FAIL m16_up_q: got %0d expected %0d", q_b, nqb); end
    n_tests++; if (wrap_b !== wb) begin n_fail++; $display("FAIL m16_up_wrap: got %b expected %b", wrap_b, wb); end
    apply(0, 0, 0, 1, 0);
    n_tests++; if (j_b !== 4'b1111 || k_b !== 4'b0000) begin n_fail++; $display("FAIL m16_down_jk: got j=%b k=%b expected 1111/0000", j_b, k_b); end
    model_step(16, mb, 0, 0, 0, 1, 0, nqb, wb);
    tick();
    mb = nqb;
    n_tests++; if (q_b !== 4'(nqb)) begin n_fail++; $display("FAIL m16_down_q: got %0d expected %0d", q_b, nqb); end
    n_tests++; if (wrap_b !== wb) begin n_fail++; $display("FAIL m16_down_wrap: got %b expected %b", wrap_b, wb); end
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'd0;
    shadow = 4'd0;
    @(posedge clk);
    test_reset();
    test_up_count();
    test_down_count();
    test_load();
    test_hold();
    test_random_shadow();
    test_mod16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
